// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate_bist self-test engine.
package gate_bist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      CHECK = 2'd2
   } state_t;

   localparam logic [1:0] OP_AND  = 2'd0;
   localparam logic [1:0] OP_OR   = 2'd1;
   localparam logic [1:0] OP_XOR  = 2'd2;
   localparam logic [1:0] OP_NAND = 2'd3;

   localparam int         NUM_VEC  = 4;
   localparam logic [1:0] LAST_VEC = 2'(NUM_VEC - 1);

endpackage

// File: rtl/gate_bist_ref.sv
// Combinational reference for the selected 2-input gate function.
module gate_bist_ref
   import gate_bist_pkg::*;
(
   input  logic [1:0] op,
   input  logic       a,
   input  logic       b,
   output logic       exp_y
);

   // expected gate output for the selected function
   always_comb begin
      exp_y = 1'b0;
      case (op)
         OP_AND:  exp_y = a & b;
         OP_OR:   exp_y = a | b;
         OP_XOR:  exp_y = a ^ b;
         OP_NAND: exp_y = ~(a & b);
         default: exp_y = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_bist.sv
// Self-test engine driving all four vectors onto an external 2-input gate.
// Optional first-failure capture is built when GATE_BIST_CAPTURE_EN is defined.
module gate_bist
   import gate_bist_pkg::*;
#(
   parameter int SETTLE = 4,
   parameter int OP     = 0
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       pat_a,
   output logic       pat_b,
   input  logic       dut_y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_cnt,
   output logic [1:0] fail_vec,
   output logic       fail_valid
);

   localparam logic [3:0] SETTLE_LAST_C = 4'(SETTLE - 1);
   localparam logic [1:0] OP_C          = 2'(OP);

   state_t     state_r, state_s;
   logic [1:0] vec_r, vec_s;
   logic [3:0] cnt_r, cnt_s;
   logic [2:0] err_r, err_s;
   logic       busy_r, busy_s;
   logic       done_r, done_s;
   logic       pass_r, pass_s;
   logic       pat_a_r, pat_b_r;
   logic       pat_a_s, pat_b_s;
   logic       exp_y_s;
   logic       mism_s;

   gate_bist_ref u_ref (
      .op    (OP_C),
      .a     (vec_r[1]),
      .b     (vec_r[0]),
      .exp_y (exp_y_s)
   );

   assign mism_s = (dut_y != exp_y_s);

   // next-state, counter and status logic
   always_comb begin
      state_s = state_r;
      vec_s   = vec_r;
      cnt_s   = cnt_r;
      err_s   = err_r;
      busy_s  = busy_r;
      done_s  = done_r;
      pass_s  = pass_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               vec_s   = 2'b00;
               cnt_s   = 4'd0;
               err_s   = 3'd0;
               done_s  = 1'b0;
               pass_s  = 1'b0;
               busy_s  = 1'b1;
               state_s = WAIT;
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r == SETTLE_LAST_C) begin
               state_s = CHECK;
            end else begin
               cnt_s = cnt_r + 4'd1;
            end
         end
         CHECK: begin
            err_s = err_r + {2'b00, mism_s};
            if (vec_r == LAST_VEC) begin
               state_s = IDLE;
               busy_s  = 1'b0;
               done_s  = 1'b1;
               pass_s  = (err_s == 3'd0);
            end else begin
               vec_s   = vec_r + 2'd1;
               cnt_s   = 4'd0;
               state_s = WAIT;
            end
         end
         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
         end
      endcase
      pat_a_s = (state_s != IDLE) & vec_s[1];
      pat_b_s = (state_s != IDLE) & vec_s[0];
   end

   // state and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         vec_r   <= 2'b00;
         cnt_r   <= 4'd0;
         err_r   <= 3'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
         pat_a_r <= 1'b0;
         pat_b_r <= 1'b0;
      end else begin
         state_r <= state_s;
         vec_r   <= vec_s;
         cnt_r   <= cnt_s;
         err_r   <= err_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         pass_r  <= pass_s;
         pat_a_r <= pat_a_s;
         pat_b_r <= pat_b_s;
      end
   end

   assign pat_a   = pat_a_r;
   assign pat_b   = pat_b_r;
   assign busy    = busy_r;
   assign done    = done_r;
   assign pass    = pass_r;
   assign err_cnt = err_r;

`ifdef GATE_BIST_CAPTURE_EN
   logic [1:0] fail_vec_r;
   logic       fail_valid_r;
   logic       start_acc_s;

   assign start_acc_s = (state_r == IDLE) & start;

   // first-mismatch capture; later mismatches leave it untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         fail_vec_r   <= 2'b00;
         fail_valid_r <= 1'b0;
      end else if (start_acc_s) begin
         fail_vec_r   <= 2'b00;
         fail_valid_r <= 1'b0;
      end else if ((state_r == CHECK) && mism_s && !fail_valid_r) begin
         fail_vec_r   <= vec_r;
         fail_valid_r <= 1'b1;
      end else begin
         fail_vec_r   <= fail_vec_r;
         fail_valid_r <= fail_valid_r;
      end
   end

   assign fail_vec   = fail_vec_r;
   assign fail_valid = fail_valid_r;
`else
   assign fail_vec   = 2'b00;
   assign fail_valid = 1'b0;
`endif

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: the gate under test is a truth table held in the bench.
module tb_gate_bist;

   logic       clk = 1'b0;
   logic       rst;
   logic       start0, start1;
   logic [3:0] tt0, tt1;
   logic       pat_a0, pat_b0, dut_y0, busy0, done0, pass0, fvalid0;
   logic       pat_a1, pat_b1, dut_y1, busy1, done1, pass1, fvalid1;
   logic [2:0] err0, err1;
   logic [1:0] fvec0, fvec1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // the gate under test: output for vector {a,b} is bit {a,b} of its truth table
   assign dut_y0 = tt0[{pat_a0, pat_b0}];
   assign dut_y1 = tt1[{pat_a1, pat_b1}];

   gate_bist #(.SETTLE(4), .OP(0)) dut (
      .clk(clk), .rst(rst), .start(start0), .pat_a(pat_a0), .pat_b(pat_b0),
      .dut_y(dut_y0), .busy(busy0), .done(done0), .pass(pass0),
      .err_cnt(err0), .fail_vec(fvec0), .fail_valid(fvalid0)
   );

   gate_bist #(.SETTLE(1), .OP(2)) dut_xor (
      .clk(clk), .rst(rst), .start(start1), .pat_a(pat_a1), .pat_b(pat_b1),
      .dut_y(dut_y1), .busy(busy1), .done(done1), .pass(pass1),
      .err_cnt(err1), .fail_vec(fvec1), .fail_valid(fvalid1)
   );

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   function automatic int ref_bit(input int op, input int a, input int b);
      case (op)
         0:       return a & b;
         1:       return a | b;
         2:       return a ^ b;
         default: return (a & b) == 1 ? 0 : 1;
      endcase
   endfunction

   // expected result of a whole run: mismatch count, first failing vector, pass
   task automatic model(input logic [3:0] tt, input int op,
                        output int err, output int fv, output int ps);
      err = 0;
      fv  = -1;
      for (int v = 0; v < 4; v++) begin
         if (int'(tt[v]) != ref_bit(op, v / 2, v % 2)) begin
            err++;
            if (fv < 0) fv = v;
         end
      end
      ps = (err == 0) ? 1 : 0;
   endtask

   // one run on the SETTLE=4 AND engine, checking timing, stimulus and status
   task automatic run0(input logic [3:0] tt, input int repulse, input int exp_err,
                       input int exp_fv, input int exp_pass, input string nm);
      int n;
      bit bad;
      @(negedge clk);
      tt0    = tt;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      n   = 0;
      bad = 1'b0;
      chk({nm, "_busy_rise"}, busy0, 1);
      chk({nm, "_done_clear"}, done0, 0);
      while (!done0 && n < 100) begin
         if (busy0 !== 1'b1 || {pat_a0, pat_b0} !== 2'(n / 5)) bad = 1'b1;
         @(negedge clk);
         n++;
         start0 = (n == repulse);
      end
      start0 = 1'b0;
      chk({nm, "_done_cycle"}, n, 20);
      chk({nm, "_pattern"}, int'(bad), 0);
      chk({nm, "_busy_end"}, busy0, 0);
      chk({nm, "_pat_idle"}, int'({pat_a0, pat_b0}), 0);
      chk({nm, "_err_cnt"}, int'(err0), exp_err);
      chk({nm, "_pass"}, pass0, exp_pass);
`ifdef GATE_BIST_CAPTURE_EN
      chk({nm, "_fail_vec"}, int'(fvec0), exp_err > 0 ? exp_fv : 0);
      chk({nm, "_fail_valid"}, fvalid0, exp_err > 0 ? 1 : 0);
`else
      chk({nm, "_fail_vec"}, int'(fvec0), 0);
      chk({nm, "_fail_valid"}, fvalid0, 0);
`endif
   endtask

   typedef struct {
      string      nm;
      logic [3:0] tt;
      int         err;
      int         fv;
      int         ps;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int e, f, p, n;
      logic [3:0] rt;

      tbl[0] = '{"and_good", 4'b1000, 0, 0, 1};
      tbl[1] = '{"stuck0",   4'b0000, 1, 3, 0};
      tbl[2] = '{"stuck1",   4'b1111, 3, 0, 0};
      tbl[3] = '{"xor_gate", 4'b0110, 3, 1, 0};
      tbl[4] = '{"or_gate",  4'b1110, 2, 1, 0};
      tbl[5] = '{"nand_gate",4'b0111, 4, 0, 0};

      rst    = 1'b1;
      start0 = 1'b0;
      start1 = 1'b0;
      tt0    = 4'b1000;
      tt1    = 4'b0110;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_pass", pass0, 0);
      chk("rst_err", int'(err0), 0);
      chk("rst_pat", int'({pat_a0, pat_b0}), 0);
      chk("rst_fail", int'({fvec0, fvalid0}), 0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run0(tbl[i].tt, -1, tbl[i].err, tbl[i].fv, tbl[i].ps, tbl[i].nm);
      end

      // start re-pulsed mid-run must not disturb the sequence
      run0(4'b1000, 7, 0, 0, 1, "repulse");

      // reset mid-run aborts to reset values
      @(negedge clk);
      tt0    = 4'b1111;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", busy0, 0);
      chk("midrst_done", done0, 0);
      chk("midrst_err", int'(err0), 0);
      chk("midrst_pat", int'({pat_a0, pat_b0}), 0);
      chk("midrst_fail", int'({fvec0, fvalid0}), 0);
      rst = 1'b0;
      run0(4'b1000, -1, 0, 0, 1, "after_rst");

      // XOR engine with SETTLE=1 finishes 8 cycles after start
      @(negedge clk);
      tt1    = 4'b0110;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("xor_s1_done_cycle", n, 8);
      chk("xor_s1_pass", pass1, 1);
      chk("xor_s1_err", int'(err1), 0);

      // random gate faults against the model
      for (int i = 0; i < 20; i++) begin
         rt = 4'($urandom);
         model(rt, 0, e, f, p);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run0(rt, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 19)) : -1,
              e, f, p, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gate_bist.md
# gate_bist

Hardware self-test engine for a 2-input logic gate. It drives all four input vectors onto an external gate under test and waits a programmable settle time for each. It then samples the gate's output, compares it against a built-in reference for the selected function, and reports an error count plus pass/done status. It is the synthesizable counterpart of our software gate testbenches: the stimulus/check end lives in silicon and the gate is the responder.

## Interface
- `SETTLE` — default 4 — number of wait cycles per vector before sampling; legal range 1..15.
- `OP` — default 0 — reference function: 0=AND, 1=OR, 2=XOR, 3=NAND.
- `clk` input 1 — single clock; all logic is rising-edge.
- `rst` input 1 — synchronous, active-high reset.
- `start` input 1 — run request; sampled only in IDLE.
- `pat_a` output 1 — stimulus bit a to the gate under test (registered).
- `pat_b` output 1 — stimulus bit b to the gate under test (registered).
- `dut_y` input 1 — gate-under-test output.
- `busy` output 1 — run in progress.
- `done` output 1 — sticky run-complete flag.
- `pass` output 1 — high with `done` when `err_cnt` is 0.
- `err_cnt` output 3 — number of mismatching vectors, 0..4.
- `fail_vec` output 2 — {a,b} of the first mismatch (only with `GATE_BIST_CAPTURE_EN`).
- `fail_valid` output 1 — `fail_vec` is valid (only with `GATE_BIST_CAPTURE_EN`).

## Operation
- States:
  - IDLE: waiting for `start`.
  - WAIT: stimulus applied, counting settle cycles.
  - CHECK: sampling and comparing `dut_y`.
- IDLE with `start`=1:
  - Clears `vec`, settle counter `cnt`, `err_cnt`, `done`, `pass` and the capture registers.
  - Sets `busy`=1 and enters WAIT.
- Stimulus order is fixed: `vec` 00 → 01 → 10 → 11. Output mapping is `pat_a`=`vec[1]`, `pat_b`=`vec[0]`.
- WAIT:
  - If `cnt`==SETTLE-1, go to CHECK.
  - Otherwise increment `cnt`.
- CHECK:
  - Compute the expected value from `OP` and `vec`.
  - On mismatch, increment `err_cnt`.
  - If `vec`==3: go to IDLE and set `busy`=0, `done`=1, `pass`=(final `err_cnt`==0).
  - Otherwise: increment `vec`, clear `cnt`, return to WAIT.
- In IDLE, `pat_a`/`pat_b` hold 0.
- `start` while `busy` is ignored.
- `start` with `done`=1 clears `done` and begins a new run.
- `err_cnt` saturation is unnecessary because 4 is the maximum and the field is 3 bits.
- `dut_y` is treated as already synchronous to `clk`. No synchronizer.

## Timing
- Reset values: state IDLE; `pat_a`=`pat_b`=0; `busy`=`done`=`pass`=0; `err_cnt`=0; `fail_vec`=0; `fail_valid`=0.
- Reset mid-run aborts immediately to the reset values. No partial status is retained.
- Let edge E0 be the edge that samples `start`. Then:
  - `busy` rises after E0.
  - Vector 00 appears on `pat_a`/`pat_b` after E0.
  - Each vector lasts SETTLE+1 cycles.
  - `dut_y` is sampled at the edge ending each vector's CHECK cycle.
- `done`, `pass` and `busy`=0 are visible after edge E0+4·(SETTLE+1). With SETTLE=4 this is 20 cycles.
- The earliest restart is the next `start` sampled in IDLE, i.e. one cycle after `done` rises.

## Configuration
- `GATE_BIST_CAPTURE_EN` defined:
  - On the first mismatch of a run, `fail_vec` captures `vec` and `fail_valid` is set.
  - Later mismatches do not overwrite the capture.
  - Both registers are cleared on `start` and on reset.
- Macro undefined:
  - The capture registers are not built.
  - `fail_vec` is tied to 0 and `fail_valid` is tied to 0.
  - Ports remain present.

## Structure
- `gate_bist_pkg` contains:
  - State enum (IDLE, WAIT, CHECK).
  - OP encoding constants (`OP_AND`, `OP_OR`, `OP_XOR`, `OP_NAND`).
  - Vector count constant `NUM_VEC`=4.
- Sub-module `gate_bist_ref`: purely combinational expected-value model with inputs `op`, `a`, `b` and output `exp_y`. It is reused by any bench scoreboard.
- The top holds the FSM, counters, status and capture logic.

## Test plan
- Good AND gate in the bench, OP=0, SETTLE=4, single `start` pulse → pattern 00,01,10,11 each held 5 cycles; `done`=1 and `pass`=1 at cycle 20; `err_cnt`=0.
- `dut_y` stuck at 0, OP=0 → `err_cnt`=1, `pass`=0; `fail_vec`=11 and `fail_valid`=1 with the macro defined, 00/0 without it.
- `dut_y` stuck at 1, OP=0 → `err_cnt`=3, `fail_vec`=00, `pass`=0.
- Good XOR gate with OP=2 and SETTLE=1 → `done` at cycle 8, `pass`=1; the same XOR gate with OP=0 → `err_cnt`=3, `fail_vec`=01.
- `start` re-pulsed at cycle 7 of a run → ignored, `done` still at cycle 20; second run started from `done` → `done` drops the cycle after `start` and rises again 20 cycles later.
- `rst` asserted at cycle 10 of a run → all outputs return to reset values the next cycle; a new `start` runs the full sequence from vector 00.
